// File: rtl/sr_bank_arbiter_if.sv
// Request/response bundle for the shared SR bit bank: per-requester command
// slices in, handshake and bank state out.
interface sr_bank_arbiter_if #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 8
);
   localparam int IDW = $clog2(N_REQ);

   logic [N_REQ-1:0]       req_valid;
   logic [N_REQ*WIDTH-1:0] req_set;
   logic [N_REQ*WIDTH-1:0] req_rst;
   logic [N_REQ-1:0]       req_ready;
   logic [WIDTH-1:0]       q;
   logic [WIDTH-1:0]       q0;
   logic [IDW-1:0]         grant_id;
   logic                   conflict;
   logic [WIDTH-1:0]       conflict_mask;
   logic                   busy;

   modport master (
      output req_valid, req_set, req_rst,
      input  req_ready, q, q0, grant_id, conflict, conflict_mask, busy
   );

   modport slave (
      input  req_valid, req_set, req_rst,
      output req_ready, q, q0, grant_id, conflict, conflict_mask, busy
   );
endinterface

// File: rtl/sr_bank_arbiter.sv
// Round-robin arbiter granting one requester at a time write access to a
// shared SR bit bank, with an optional lock-out window after each command.
module sr_bit_cell (
   input  logic q_i,
   input  logic set_i,
   input  logic rst_i,
   output logic nxt_o,
   output logic cfl_o
);
   // Set and reset together hold the bit rather than resolving to either side.
   assign nxt_o = (set_i & ~rst_i) | (q_i & ~(rst_i & ~set_i));
   assign cfl_o = set_i & rst_i;
endmodule

module sr_bank_arbiter #(
   parameter int N_REQ    = 4,
   parameter int WIDTH    = 8,
   parameter int HOLD_CYC = 2
) (
   input logic             clk,
   input logic             rst_n,
   sr_bank_arbiter_if.slave bank_if
);
   localparam int IDW = $clog2(N_REQ);

   typedef enum logic {IDLE, HOLD} state_e;

   state_e           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [IDW-1:0]   ptr_q, ptr_d, gid_q, gid_d, win_idx;
   logic [WIDTH-1:0] q_q, q_d, cmask_q, cmask_d;
   logic             cfl_q, cfl_d;
   logic             win_found, hs;
   logic [WIDTH-1:0] g_set, g_rst, q_nxt, cfl_bits;
   logic [N_REQ-1:0] ready;
   int               idx;

   // Search upward from the last grant so every requester gets a turn.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      idx       = 0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = (int'(ptr_q) + k) % N_REQ;
         if (!win_found && bank_if.req_valid[idx]) begin
            win_found = 1'b1;
            win_idx   = IDW'(idx);
         end
      end
   end

   assign ready = (rst_n && state_q == IDLE && win_found)
                  ? ({{(N_REQ-1){1'b0}}, 1'b1} << win_idx) : '0;
   assign hs    = |(bank_if.req_valid & ready);

   assign g_set = bank_if.req_set[int'(win_idx)*WIDTH +: WIDTH];
   assign g_rst = bank_if.req_rst[int'(win_idx)*WIDTH +: WIDTH];

   for (genvar b = 0; b < WIDTH; b++) begin : g_bit
      sr_bit_cell u_cell (
         .q_i  (q_q[b]),
         .set_i(g_set[b]),
         .rst_i(g_rst[b]),
         .nxt_o(q_nxt[b]),
         .cfl_o(cfl_bits[b])
      );
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      gid_d   = gid_q;
      q_d     = q_q;
      cfl_d   = 1'b0;
      cmask_d = '0;
      case (state_q)
         IDLE: begin
            if (hs) begin
               ptr_d   = win_idx;
               gid_d   = win_idx;
               q_d     = q_nxt;
               cfl_d   = |cfl_bits;
               cmask_d = cfl_bits;
               if (HOLD_CYC > 0) begin
                  state_d = HOLD;
                  cnt_d   = 4'(HOLD_CYC - 1);
               end
            end
         end
         HOLD: begin
            if (cnt_q == 4'd0) state_d = IDLE;
            else               cnt_d   = cnt_q - 4'd1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ptr_q   <= IDW'(N_REQ - 1);
         gid_q   <= '0;
         q_q     <= '0;
         cfl_q   <= 1'b0;
         cmask_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         gid_q   <= gid_d;
         q_q     <= q_d;
         cfl_q   <= cfl_d;
         cmask_q <= cmask_d;
      end
   end

   assign bank_if.req_ready     = ready;
   assign bank_if.q             = q_q;
   assign bank_if.q0            = ~q_q;
   assign bank_if.grant_id      = gid_q;
   assign bank_if.conflict      = cfl_q;
   assign bank_if.conflict_mask = cmask_q;
   assign bank_if.busy          = (state_q != IDLE);
endmodule
